// File: rtl/hazard_scoreboard.sv
// Countdown-scoreboard hazard unit: one latency counter per register decides
// IF/ID hold and ID/EX bubble for EX consumers and ID-stage branch compares.
module hazard_scoreboard #(
  parameter int REG_ADDR_W   = 5,
  parameter int LAT_W        = 3,
  parameter int BRANCH_EXTRA = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issueValid,
  input  logic [REG_ADDR_W-1:0] registerRsID,
  input  logic [REG_ADDR_W-1:0] registerRtID,
  input  logic                  useRsID,
  input  logic                  useRtID,
  input  logic                  branchID,
  input  logic                  regWriteID,
  input  logic [REG_ADDR_W-1:0] registerRdID,
  input  logic [LAT_W-1:0]      latencyID,
  output logic                  stall,
  output logic                  flush,
  output logic [CNT_W-1:0]      stallCycles
);

  localparam int NREG  = 1 << REG_ADDR_W;
  localparam int CTR_W = LAT_W + 1;
  localparam logic [CTR_W-1:0] EXTRA = CTR_W'(BRANCH_EXTRA);

  logic [CTR_W-1:0] cnt_q [NREG];
  logic [CTR_W-1:0] cnt_d [NREG];
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] stall_cycles_d;
  logic             rs_blk_s;
  logic             rt_blk_s;
  logic             stall_s;
  logic             load_s;

  // Branches compare in ID and need the value fully settled; EX consumers
  // can tolerate BRANCH_EXTRA remaining cycles thanks to forwarding.
  function automatic logic src_blocked(input logic                  used_i,
                                       input logic [REG_ADDR_W-1:0] reg_i,
                                       input logic                  br_i,
                                       input logic [CTR_W-1:0]      cnt_i);
    logic blk;
    if (!used_i || (reg_i == REG_ADDR_W'(0))) begin
      blk = 1'b0;
    end else if (br_i) begin
      blk = (cnt_i != CTR_W'(0));
    end else begin
      blk = (cnt_i > EXTRA);
    end
    return blk;
  endfunction

  always_comb begin
    rs_blk_s = src_blocked(useRsID, registerRsID, branchID, cnt_q[registerRsID]);
    rt_blk_s = src_blocked(useRtID, registerRtID, branchID, cnt_q[registerRtID]);
    stall_s  = issueValid & (rs_blk_s | rt_blk_s);
    load_s   = issueValid & ~stall_s & regWriteID & (registerRdID != REG_ADDR_W'(0));

    for (int i = 0; i < NREG; i++) begin
      if (load_s && (registerRdID == REG_ADDR_W'(i))) begin
        cnt_d[i] = CTR_W'(latencyID) + EXTRA;
      end else if (cnt_q[i] != CTR_W'(0)) begin
        cnt_d[i] = cnt_q[i] - CTR_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
    cnt_d[0] = CTR_W'(0);

    if (stall_s && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= CTR_W'(0);
      end
      stall_cycles_q <= CNT_W'(0);
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall       = stall_s;
  assign flush       = stall_s;
  assign stallCycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: hand-derived per-cycle stall expectations are queued as
// stimulus is driven and compared on the following falling edge.
module tb_hazard_scoreboard;

  localparam int RW = 5;
  localparam int LW = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          issueValid;
  logic [RW-1:0] registerRsID;
  logic [RW-1:0] registerRtID;
  logic          useRsID;
  logic          useRtID;
  logic          branchID;
  logic          regWriteID;
  logic [RW-1:0] registerRdID;
  logic [LW-1:0] latencyID;
  logic          stall;
  logic          flush;
  logic [CW-1:0] stallCycles;

  typedef struct {
    logic stall;
    int   id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  hazard_scoreboard #(
    .REG_ADDR_W  (RW),
    .LAT_W       (LW),
    .BRANCH_EXTRA(1),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issueValid  (issueValid),
    .registerRsID(registerRsID),
    .registerRtID(registerRtID),
    .useRsID     (useRsID),
    .useRtID     (useRtID),
    .branchID    (branchID),
    .regWriteID  (regWriteID),
    .registerRdID(registerRdID),
    .latencyID   (latencyID),
    .stall       (stall),
    .flush       (flush),
    .stallCycles (stallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pop one expectation per falling edge while stimulus is queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_val($sformatf("stall#%0d", e.id), int'(stall), int'(e.stall));
      check_val($sformatf("flush#%0d", e.id), int'(flush), int'(e.stall));
    end
  end

  task automatic step(input logic v, input logic br, input logic wr,
                      input logic urs, input logic urt,
                      input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                      input logic [RW-1:0] rd, input logic [LW-1:0] lat,
                      input logic exp_stall);
    exp_t e;
    issueValid   = v;
    branchID     = br;
    regWriteID   = wr;
    useRsID      = urs;
    useRtID      = urt;
    registerRsID = rs;
    registerRtID = rt;
    registerRdID = rd;
    latencyID    = lat;
    e.stall      = exp_stall;
    e.id         = step_id;
    step_id++;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic prod(input logic [RW-1:0] rd, input logic [LW-1:0] lat);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, rd, lat, 1'b0);
  endtask

  // n stalled cycles followed by the issuing cycle; source on Rs or Rt.
  task automatic consume(input logic [RW-1:0] r, input logic br, input int n,
                         input logic on_rt);
    for (int i = 0; i < n; i++) begin
      step(1'b1, br, 1'b0, ~on_rt, on_rt, on_rt ? 5'd0 : r, on_rt ? r : 5'd0,
           5'd0, 5'd0, 1'b1);
    end
    step(1'b1, br, 1'b0, ~on_rt, on_rt, on_rt ? 5'd0 : r, on_rt ? r : 5'd0,
         5'd0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    issueValid = 1'b0;
    regWriteID = 1'b0;
    useRsID    = 1'b0;
    useRtID    = 1'b0;
    branchID   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held with a hazard-looking instruction presented.
    rst_n        = 1'b0;
    issueValid   = 1'b1;
    branchID     = 1'b1;
    useRsID      = 1'b1;
    useRtID      = 1'b1;
    registerRsID = 5'd8;
    registerRtID = 5'd9;
    regWriteID   = 1'b1;
    registerRdID = 5'd8;
    latencyID    = 5'd5;
    #3;
    check_val("rst_stall", int'(stall), 0);
    check_val("rst_flush", int'(flush), 0);
    check_val("rst_cnt", int'(stallCycles), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    issueValid = 1'b0;
    regWriteID = 1'b0;
    rst_n      = 1'b1;
    idle();
    consume(5'd8, 1'b1, 0, 1'b0);
    idle();
    check_val("post_rst_cnt", int'(stallCycles), 0);

    // Load then ALU use.
    do_reset();
    prod(5'd8, 5'd1);
    consume(5'd8, 1'b0, 1, 1'b0);
    idle();
    check_val("load_use_cnt", int'(stallCycles), 1);

    // ALU then branch.
    do_reset();
    prod(5'd8, 5'd0);
    consume(5'd8, 1'b1, 1, 1'b0);
    idle();
    check_val("alu_br_cnt", int'(stallCycles), 1);

    // Load then branch, source on Rt.
    do_reset();
    prod(5'd8, 5'd1);
    consume(5'd8, 1'b1, 2, 1'b1);
    idle();
    check_val("load_br_cnt", int'(stallCycles), 2);

    // ALU then EX consumer: no stall.
    do_reset();
    prod(5'd9, 5'd0);
    consume(5'd9, 1'b0, 0, 1'b1);

    // Multi-cycle producer.
    do_reset();
    prod(5'd10, 5'd5);
    consume(5'd10, 1'b0, 5, 1'b0);
    idle();
    check_val("mul_cnt", int'(stallCycles), 5);

    // Unrelated consumer in between, then the dependent.
    do_reset();
    prod(5'd10, 5'd5);
    consume(5'd11, 1'b0, 0, 1'b0);
    consume(5'd10, 1'b0, 4, 1'b0);
    idle();
    check_val("unrel_cnt", int'(stallCycles), 4);

    // WAW: younger ALU result replaces the pending multiply.
    do_reset();
    prod(5'd8, 5'd5);
    prod(5'd8, 5'd0);
    consume(5'd8, 1'b0, 0, 1'b0);
    idle();
    check_val("waw_cnt", int'(stallCycles), 0);

    // Writes to $0 never create a hazard.
    do_reset();
    prod(5'd0, 5'd20);
    consume(5'd0, 1'b1, 0, 1'b0);
    consume(5'd0, 1'b1, 0, 1'b1);

    // Reset asserted asynchronously in the middle of a stall.
    do_reset();
    prod(5'd10, 5'd5);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10, 5'd0, 5'd0, 5'd0, 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_stall", int'(stall), 0);
    check_val("mid_rst_cnt", int'(stallCycles), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    consume(5'd10, 1'b0, 0, 1'b0);
    idle();
    check_val("after_mid_rst_cnt", int'(stallCycles), 0);

    // Counter saturation: 20 consecutive stall cycles with a 4-bit counter.
    do_reset();
    prod(5'd12, 5'd20);
    consume(5'd12, 1'b0, 20, 1'b0);
    idle();
    check_val("sat_cnt", int'(stallCycles), 15);

    if (exp_q.size() != 0) begin
      check_val("queue_drain", exp_q.size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
